uart_serial: RTL and testbench

- Full-duplex 8N1 UART: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- The bit rate is programmable at runtime through a divider input.
- Sits between on-chip byte producers/consumers and the serial pins. Used in the VGA terminal design both as the host-side stimulus generator and as the console receiver.
- An optional ECHO mode retransmits every received byte.

---
 rtl/uart_serial.sv | 218 +++++++++++++++++++++
 tb/tb_uart_serial.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial.sv
// Full-duplex 8N1 UART with a runtime bit-rate divider and optional echo of received bytes.
// TX and RX are independent FSMs; each latches the divider at the start of its own frame.
module uart_serial (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ECHO,
  input  logic        UART_RX,
  output logic        UART_TX,
  input  logic [19:0] clockDividerValue,
  output logic [7:0]  dataOutRx,
  output logic        dataOutRxAvailable,
  input  logic [7:0]  dataInTx,
  input  logic        dataInTxValid,
  output logic        dataInTxBusy,
  output logic        rxError,
  output logic        rxBitTick,
  output logic        txBitTick
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } TxState;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } RxState;

  TxState      txState, txStateNext;
  logic [19:0] txDiv;
  logic [19:0] txCount;
  logic [7:0]  txShift;
  logic [2:0]  txBitIdx;
  logic        txWrap;
  logic        txLoad;
  logic [7:0]  txLoadByte;
  logic        echoReq;

  RxState      rxState, rxStateNext;
  logic        rxSync1, rxSync2, rxPrev;
  logic [19:0] rxDiv;
  logic [19:0] rxCount;
  logic [2:0]  rxBitIdx;
  logic [7:0]  rxShift;
  logic        rxArm;
  logic        rxSampleStart;
  logic        rxSampleBit;
  logic        rxGood;
  logic        rxBad;

  // An echo takes priority over an external request arriving in the same cycle.
  assign echoReq = ECHO && dataOutRxAvailable;

  always_comb begin
    txStateNext  = txState;
    txLoad       = 1'b0;
    txLoadByte   = dataInTx;
    txWrap       = (txState != TX_IDLE) && (txCount == txDiv - 20'd1);
    txBitTick    = txWrap;
    dataInTxBusy = (txState != TX_IDLE);
    unique case (txState)
      TX_IDLE: begin
        if (echoReq) begin
          txLoad     = 1'b1;
          txLoadByte = dataOutRx;
        end else if (dataInTxValid) begin
          txLoad = 1'b1;
        end
        if (txLoad) txStateNext = TX_START;
      end
      TX_START: if (txWrap) txStateNext = TX_DATA;
      TX_DATA:  if (txWrap && txBitIdx == 3'd7) txStateNext = TX_STOP;
      TX_STOP:  if (txWrap) txStateNext = TX_IDLE;
      default:  txStateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) txState <= TX_IDLE;
    else       txState <= txStateNext;
  end

  // UART_TX is registered so the pin never glitches while the shifter moves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txDiv    <= '0;
      txCount  <= '0;
      txShift  <= '0;
      txBitIdx <= '0;
      UART_TX  <= 1'b1;
    end else if (txLoad) begin
      txDiv    <= clockDividerValue;
      txShift  <= txLoadByte;
      txCount  <= '0;
      txBitIdx <= '0;
      UART_TX  <= 1'b0;
    end else if (txState != TX_IDLE) begin
      if (txWrap) begin
        txCount <= '0;
        unique case (txState)
          TX_START: UART_TX <= txShift[0];
          TX_DATA: begin
            if (txBitIdx == 3'd7) begin
              UART_TX <= 1'b1;
            end else begin
              UART_TX  <= txShift[1];
              txShift  <= {1'b0, txShift[7:1]};
              txBitIdx <= txBitIdx + 3'd1;
            end
          end
          TX_STOP: UART_TX <= 1'b1;
          default: UART_TX <= 1'b1;
        endcase
      end else begin
        txCount <= txCount + 20'd1;
      end
    end
  end

  // Synchronizer resets to idle-high so no false start edge appears after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= UART_RX;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
    end
  end

  always_comb begin
    rxStateNext   = rxState;
    rxArm         = 1'b0;
    rxSampleStart = (rxState == RX_START) && (rxCount == (rxDiv >> 1) - 20'd1);
    rxSampleBit   = ((rxState == RX_DATA) || (rxState == RX_STOP)) &&
                    (rxCount == rxDiv - 20'd1);
    rxBitTick     = rxSampleStart || rxSampleBit;
    rxGood        = (rxState == RX_STOP) && rxSampleBit && rxSync2;
    rxBad         = (rxState == RX_STOP) && rxSampleBit && !rxSync2;
    unique case (rxState)
      RX_IDLE: begin
        if (rxPrev && !rxSync2) begin
          rxArm       = 1'b1;
          rxStateNext = RX_START;
        end
      end
      RX_START:     if (rxSampleStart) rxStateNext = rxSync2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rxSampleBit && rxBitIdx == 3'd7) rxStateNext = RX_STOP;
      RX_STOP:      if (rxSampleBit) rxStateNext = rxSync2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rxSync2) rxStateNext = RX_IDLE;
      default:      rxStateNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rxState <= RX_IDLE;
    else       rxState <= rxStateNext;
  end

  // A framing error keeps the last good byte and sticks until a clean frame arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxDiv              <= '0;
      rxCount            <= '0;
      rxBitIdx           <= '0;
      rxShift            <= '0;
      dataOutRx          <= '0;
      dataOutRxAvailable <= 1'b0;
      rxError            <= 1'b0;
    end else begin
      dataOutRxAvailable <= rxGood;
      if (rxGood) begin
        dataOutRx <= rxShift;
        rxError   <= 1'b0;
      end
      if (rxBad) rxError <= 1'b1;
      unique case (rxState)
        RX_IDLE: begin
          if (rxArm) begin
            rxDiv   <= clockDividerValue;
            rxCount <= '0;
          end
        end
        RX_START: begin
          if (rxSampleStart) begin
            rxCount  <= '0;
            rxBitIdx <= '0;
          end else begin
            rxCount <= rxCount + 20'd1;
          end
        end
        RX_DATA: begin
          if (rxSampleBit) begin
            rxCount  <= '0;
            rxShift  <= {rxSync2, rxShift[7:1]};
            rxBitIdx <= rxBitIdx + 3'd1;
          end else begin
            rxCount <= rxCount + 20'd1;
          end
        end
        RX_STOP: begin
          if (rxSampleBit) rxCount <= '0;
          else             rxCount <= rxCount + 20'd1;
        end
        default: rxCount <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serial.sv
// Self-checking bench for uart_serial: directed steps with random bytes and dividers,
// checked against frame waveforms computed from the 8N1 bit rules.
module tb_uart_serial;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ECHO;
  logic        UART_TX;
  logic [19:0] divider;
  logic [7:0]  dataOutRx;
  logic        dataOutRxAvailable;
  logic [7:0]  dataInTx;
  logic        dataInTxValid;
  logic        dataInTxBusy;
  logic        rxError;
  logic        rxBitTick;
  logic        txBitTick;
  logic        rxDrive;
  logic        loopback;
  logic        rxLine;

  int total = 0;
  int bad   = 0;

  assign rxLine = loopback ? UART_TX : rxDrive;

  always #5 clk = ~clk;

  uart_serial dut (
    .clk                (clk),
    .rstn               (rstn),
    .ECHO               (ECHO),
    .UART_RX            (rxLine),
    .UART_TX            (UART_TX),
    .clockDividerValue  (divider),
    .dataOutRx          (dataOutRx),
    .dataOutRxAvailable (dataOutRxAvailable),
    .dataInTx           (dataInTx),
    .dataInTxValid      (dataInTxValid),
    .dataInTxBusy       (dataInTxBusy),
    .rxError            (rxError),
    .rxBitTick          (rxBitTick),
    .txBitTick          (txBitTick)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Frame bit i of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frameBit(input logic [7:0] b, input int i, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    return bits[i];
  endfunction

  // Sends one byte through the transmitter and compares every cycle against the ideal frame.
  task automatic txFrameCheck(input logic [7:0] b, input int d, input string tag);
    int waveErr = 0;
    int tickErr = 0;
    int ticks = 0;
    int busyCycles = 0;
    @(posedge clk);
    #1;
    divider       = 20'(d);
    dataInTx      = b;
    dataInTxValid = 1'b1;
    @(posedge clk);
    #1;
    dataInTxValid = 1'b0;
    dataInTx      = 8'($urandom);
    for (int k = 0; k < 10 * d; k++) begin
      @(negedge clk);
      if (k == 3 * d) divider = 20'(d + 7);
      if (UART_TX !== frameBit(b, k / d, 1'b1)) waveErr++;
      if (dataInTxBusy === 1'b1) busyCycles++;
      if (txBitTick !== ((k % d) == d - 1)) tickErr++;
      if (txBitTick === 1'b1) ticks++;
    end
    @(negedge clk);
    checkOutput({tag, "_wave"}, waveErr, 0);
    checkOutput({tag, "_busyCycles"}, busyCycles, 10 * d);
    checkOutput({tag, "_tickCount"}, ticks, 10);
    checkOutput({tag, "_tickPos"}, tickErr, 0);
    checkOutput({tag, "_busyEnd"}, dataInTxBusy, 0);
    checkOutput({tag, "_txIdle"}, UART_TX, 1);
    divider = 20'(d);
  endtask

  // Drives one serial frame on UART_RX followed by two idle bit times, watching the RX outputs.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int d,
                               output int availCount, output logic [7:0] lastData,
                               output int tickCount);
    availCount = 0;
    tickCount  = 0;
    lastData   = 8'h00;
    divider    = 20'(d);
    for (int c = 0; c < 12 * d; c++) begin
      @(posedge clk);
      #1;
      rxDrive = (c < 10 * d) ? frameBit(b, c / d, stopBit) : 1'b1;
      @(negedge clk);
      if (dataOutRxAvailable === 1'b1) begin
        availCount++;
        lastData = dataOutRx;
      end
      if (rxBitTick === 1'b1) tickCount++;
    end
  endtask

  logic [7:0] msg [14] = '{8'h68, 8'h65, 8'h18, 8'h6c, 8'h6c, 8'h6f, 8'h2c,
                          8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21};
  logic [7:0] got [$];
  logic       txArr [];
  logic [7:0] b1, b2, b3, rb, lastData;
  int         av, ticks, d, availIdx, waveErr, rises, drvTimeout, errSeen;
  logic       prevBusy;

  initial begin
    rstn          = 1'b0;
    ECHO          = 1'b0;
    divider       = 20'd131;
    dataInTx      = 8'h00;
    dataInTxValid = 1'b0;
    rxDrive       = 1'b1;
    loopback      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", UART_TX, 1);
    checkOutput("rst_busy", dataInTxBusy, 0);
    checkOutput("rst_rxData", dataOutRx, 0);
    checkOutput("rst_avail", dataOutRxAvailable, 0);
    checkOutput("rst_rxErr", rxError, 0);
    checkOutput("rst_rxTick", rxBitTick, 0);
    checkOutput("rst_txTick", txBitTick, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);

    // Directed 'h' frame at D=131, then random bytes at random and minimum dividers
    txFrameCheck(8'h68, 131, "tx_h");
    for (int i = 0; i < 3; i++) txFrameCheck(8'($urandom), int'($urandom_range(40, 9)), "tx_rand");
    txFrameCheck(8'($urandom), 8, "tx_dmin");

    // Reset in the middle of a transmit frame
    @(posedge clk);
    #1;
    divider = 20'd131; dataInTx = 8'h55; dataInTxValid = 1'b1;
    @(posedge clk);
    #1 dataInTxValid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("midrst_preBusy", dataInTxBusy, 1);
    checkOutput("midrst_preTx", UART_TX, 0);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_tx", UART_TX, 1);
    checkOutput("midrst_busy", dataInTxBusy, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);

    // Framing: good, bad stop, good
    d  = int'($urandom_range(48, 8));
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    applyStimulus(b1, 1'b1, d, av, lastData, ticks);
    checkOutput("frm1_avail", av, 1);
    checkOutput("frm1_data", dataOutRx, b1);
    checkOutput("frm1_err", rxError, 0);
    checkOutput("frm1_ticks", ticks, 10);
    applyStimulus(b2, 1'b0, d, av, lastData, ticks);
    checkOutput("frm2_avail", av, 0);
    checkOutput("frm2_err", rxError, 1);
    checkOutput("frm2_dataHeld", dataOutRx, b1);
    checkOutput("frm2_ticks", ticks, 10);
    applyStimulus(b3, 1'b1, d, av, lastData, ticks);
    checkOutput("frm3_avail", av, 1);
    checkOutput("frm3_data", lastData, b3);
    checkOutput("frm3_errCleared", rxError, 0);

    // Random good frames, including the minimum divider
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      d  = (i == 0) ? 8 : int'($urandom_range(48, 8));
      applyStimulus(rb, 1'b1, d, av, lastData, ticks);
      checkOutput("rxr_avail", av, 1);
      checkOutput("rxr_data", lastData, rb);
    end

    // Glitch: 20 low cycles at D=131
    divider = 20'd131;
    av = 0; ticks = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1 rxDrive = (c < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rxBitTick === 1'b1) ticks++;
      if (dataOutRxAvailable === 1'b1) av++;
    end
    checkOutput("glitch_ticks", ticks, 1);
    checkOutput("glitch_avail", av, 0);
    checkOutput("glitch_err", rxError, 0);

    // Loopback of a 14-byte message with requests issued as soon as TX frees up
    loopback   = 1'b1;
    d          = int'($urandom_range(40, 16));
    divider    = 20'(d);
    drvTimeout = 0;
    errSeen    = 0;
    got.delete();
    fork
      begin : drv
        for (int i = 0; i < 14; i++) begin
          int guard;
          guard = 0;
          do begin
            @(negedge clk);
            guard++;
          end while (dataInTxBusy !== 1'b0 && guard < 20 * d);
          if (guard >= 20 * d) drvTimeout = 1;
          dataInTx      = msg[i];
          dataInTxValid = 1'b1;
          @(posedge clk);
          #1 dataInTxValid = 1'b0;
        end
      end
      begin : mon
        int budget;
        budget = 0;
        while (got.size() < 14 && budget < 16 * 14 * d) begin
          @(negedge clk);
          budget++;
          if (dataOutRxAvailable === 1'b1) got.push_back(dataOutRx);
          if (rxError === 1'b1) errSeen = 1;
        end
      end
    join
    loopback = 1'b0;
    checkOutput("loop_drvTimeout", drvTimeout, 0);
    checkOutput("loop_count", got.size(), 14);
    for (int i = 0; i < 14; i++) begin
      if (i < got.size()) checkOutput("loop_byte", got[i], msg[i]);
      else checkOutput("loop_byteMissing", i, 14);
    end
    checkOutput("loop_err", errSeen, 0);
    repeat (3 * d) @(posedge clk);

    // Echo: 0x41 retransmitted starting the cycle after the available pulse
    ECHO     = 1'b1;
    d        = 131;
    divider  = 20'(d);
    txArr    = new[22 * d];
    availIdx = -1;
    for (int c = 0; c < 22 * d; c++) begin
      @(posedge clk);
      #1 rxDrive = (c < 10 * d) ? frameBit(8'h41, c / d, 1'b1) : 1'b1;
      @(negedge clk);
      txArr[c] = UART_TX;
      if (dataOutRxAvailable === 1'b1 && availIdx < 0) availIdx = c;
    end
    checkOutput("echo_availSeen", 32'(availIdx >= 0), 1);
    if (availIdx >= 0) begin
      waveErr = 0;
      for (int k = 0; k < 10 * d; k++)
        if (txArr[availIdx + 1 + k] !== frameBit(8'h41, k / d, 1'b1)) waveErr++;
      checkOutput("echo_txIdleAtPulse", txArr[availIdx], 1);
      checkOutput("echo_wave", waveErr, 0);
    end

    // Echo dropped because TX is already busy when the byte arrives
    rises    = 0;
    av       = 0;
    prevBusy = 1'b0;
    rb       = 8'($urandom);
    for (int c = 0; c < 24 * d; c++) begin
      @(posedge clk);
      #1;
      dataInTxValid = (c == 0);
      dataInTx      = 8'hc3;
      rxDrive       = (c >= 1 && c < 10 * d + 1) ? frameBit(rb, (c - 1) / d, 1'b1) : 1'b1;
      @(negedge clk);
      if (dataInTxBusy === 1'b1 && prevBusy === 1'b0) rises++;
      prevBusy = dataInTxBusy;
      if (dataOutRxAvailable === 1'b1) av++;
    end
    checkOutput("echoDrop_rxAvail", av, 1);
    checkOutput("echoDrop_txStarts", rises, 1);
    checkOutput("echoDrop_txIdle", UART_TX, 1);
    ECHO = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
